scoreboard_issue_ctrl: RTL

//   In-order issue controller for the 5-stage MIPS pipeline. It sits between

---
 rtl/scoreboard_issue_ctrl_if.sv | 9 +
 rtl/scoreboard_issue_ctrl.sv | 121 ++++++++++++
 2 files changed

// File: rtl/scoreboard_issue_ctrl_if.sv
// Valid/ready instruction stream between pipeline stages; master drives instr/valid, slave drives ready.
interface scoreboard_issue_ctrl_if;
  logic [31:0] instr;
  logic        valid;
  logic        ready;

  modport master (output instr, output valid, input ready);
  modport slave  (input instr, input valid, output ready);
endinterface

// File: rtl/scoreboard_issue_ctrl.sv
// In-order issue controller with a per-register pending-write scoreboard and one registered issue stage.
// Define SB_STALL_CNT_EN to build the saturating stall counter; otherwise stall_count is tied to zero.
module scoreboard_issue_ctrl #(
  parameter int ALU_LAT  = 0,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  scoreboard_issue_ctrl_if.slave  in_if,
  scoreboard_issue_ctrl_if.master out_if,
  input  logic                   flush,
  output logic                   stall,
  output logic [15:0]            stall_count
);
  localparam logic [CNT_W-1:0] ALU_CNT  = CNT_W'(ALU_LAT);
  localparam logic [CNT_W-1:0] LOAD_CNT = CNT_W'(LOAD_LAT);

  logic [CNT_W-1:0] cnt [32];
  logic [5:0]       opcode;
  logic [5:0]       funct;
  logic [4:0]       rs, rt, rd;
  logic [4:0]       src_a, src_b, dst;
  logic [CNT_W-1:0] lat;
  logic             hazard;
  logic             issue;
  logic             unused_bits;

  assign opcode      = in_if.instr[31:26];
  assign rs          = in_if.instr[25:21];
  assign rt          = in_if.instr[20:16];
  assign rd          = in_if.instr[15:11];
  assign funct       = in_if.instr[5:0];
  assign unused_bits = ^in_if.instr[10:6];

  // Unused operand slots decode to $0, which is never pending.
  always_comb begin
    src_a = '0;
    src_b = '0;
    dst   = '0;
    lat   = '0;
    case (opcode)
      6'b000000: begin
        if (funct == 6'b100000 || funct == 6'b100010) begin
          src_a = rs;
          src_b = rt;
          dst   = rd;
          lat   = ALU_CNT;
        end
      end
      6'b001000: begin
        src_a = rs;
        dst   = rt;
        lat   = ALU_CNT;
      end
      6'b100011: begin
        src_a = rs;
        dst   = rt;
        lat   = LOAD_CNT;
      end
      6'b101011, 6'b000100: begin
        src_a = rs;
        src_b = rt;
      end
      default: ;
    endcase
  end

  assign hazard = (src_a != '0 && cnt[src_a] != '0) ||
                  (src_b != '0 && cnt[src_b] != '0) ||
                  (dst   != '0 && cnt[dst]   != '0);

  assign in_if.ready = !hazard && (!out_if.valid || out_if.ready) && !flush;
  assign issue       = in_if.valid && in_if.ready;
  assign stall       = in_if.valid && hazard;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_if.valid <= 1'b0;
      out_if.instr <= '0;
    end else if (flush) begin
      out_if.valid <= 1'b0;
    end else if (issue) begin
      out_if.valid <= 1'b1;
      out_if.instr <= in_if.instr;
    end else if (out_if.ready) begin
      out_if.valid <= 1'b0;
    end
  end

  // Countdowns advance only when execute accepts; a fresh issue reloads its destination.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) cnt[i] <= '0;
    end else begin
      cnt[0] <= '0;
      for (int i = 1; i < 32; i++) begin
        if (issue && dst == 5'(i) && lat != '0)
          cnt[i] <= lat;
        else if (out_if.ready && cnt[i] != '0)
          cnt[i] <= cnt[i] - CNT_W'(1);
      end
    end
  end

`ifdef SB_STALL_CNT_EN
  logic [15:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n)
      stall_cnt_q <= '0;
    else if (stall && stall_cnt_q != 16'hFFFF)
      stall_cnt_q <= stall_cnt_q + 16'd1;
  end

  assign stall_count = stall_cnt_q;
`else
  assign stall_count = 16'h0000;
`endif

endmodule
